mem_arbiter: RTL

//  Shares the single-port instruction/data memory between the CPU fetch port and the CPU data
//  (ldr/str) port. Accepts one request at a time, drives memory address/data/write, captures

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter.
// MEM_ARB_RR_EN (optional define) selects round-robin arbitration instead of data-first priority.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch and data ports.
// MEM_ARB_RR_EN defined: round-robin on contention; undefined: data port always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req_i,
  input  logic d_req_i,
`ifdef MEM_ARB_RR_EN
  input  logic last_d_i,
`endif
  output logic any_o,
  output logic win_d_o
);

  owner_e win;

  always_comb begin
    any_o = if_req_i | d_req_i;
`ifdef MEM_ARB_RR_EN
    if (if_req_i && d_req_i) begin
      win = (owner_e'(last_d_i) == OWN_D) ? OWN_IF : OWN_D;
    end else begin
      win = d_req_i ? OWN_D : OWN_IF;
    end
`else
    win = d_req_i ? OWN_D : OWN_IF;
`endif
    win_d_o = (win == OWN_D);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch and data ports share one memory, one access per 3 cycles.
// MEM_ARB_RR_EN (optional define) enables round-robin with a last-winner register.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state_q;
  owner_e            owner_q;
  logic              we_q, ok_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic              if_rvalid_q, d_rvalid_q, if_err_q, d_err_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic              any_req, win_d, grant;
  logic [ADDR_W-1:0] addr_d;
  logic              ok_d, we_d;
  logic [DATA_W-1:0] rdata_d;

`ifdef MEM_ARB_RR_EN
  logic last_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else if (grant) begin
      last_d_q <= win_d;
    end
  end
`endif

  mem_arb_pick u_pick (
    .if_req_i (if_req),
    .d_req_i  (d_req),
`ifdef MEM_ARB_RR_EN
    .last_d_i (last_d_q),
`endif
    .any_o    (any_req),
    .win_d_o  (win_d)
  );

  // Grant is combinational so the requester sees it in the same IDLE cycle; gated during reset.
  assign grant   = rst_n && (state_q == IDLE) && any_req;
  assign if_gnt  = grant && !win_d;
  assign d_gnt   = grant && win_d;
  assign addr_d  = win_d ? d_addr : if_addr;
  assign ok_d    = addr_in_range(32'(addr_d), DEPTH);
  assign we_d    = win_d && d_we;
  assign rdata_d = (ok_q && !we_q) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      ok_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q     <= ACCESS;
            owner_q     <= win_d ? OWN_D : OWN_IF;
            we_q        <= we_d;
            ok_q        <= ok_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= win_d ? d_wdata : '0;
            mem_we_q    <= we_d && ok_d;
          end
        end
        ACCESS: begin
          // mem_rdata was refreshed on the mid-cycle negedge for mem_addr_q
          state_q     <= RESP;
          mem_we_q    <= 1'b0;
          if_rvalid_q <= (owner_q == OWN_IF);
          d_rvalid_q  <= (owner_q == OWN_D);
          if_err_q    <= (owner_q == OWN_IF) && !ok_q;
          d_err_q     <= (owner_q == OWN_D) && !ok_q;
          if_rdata_q  <= (owner_q == OWN_IF) ? rdata_d : '0;
          d_rdata_q   <= (owner_q == OWN_D) ? rdata_d : '0;
        end
        RESP: begin
          state_q     <= IDLE;
          if_rvalid_q <= 1'b0;
          d_rvalid_q  <= 1'b0;
          if_err_q    <= 1'b0;
          d_err_q     <= 1'b0;
          if_rdata_q  <= '0;
          d_rdata_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign busy      = (state_q != IDLE);

endmodule
